// File: rtl/pong_display_pkg.sv
// rtl/pong_display_pkg.sv - shared constants, slot map and FSM states for the score display scanner
package pong_display_pkg;

    localparam int DIGIT_W   = 4;
    localparam int NUM_SLOTS = 4;
    localparam int MAX_SCORE = 99;
    localparam int BCD_ITER  = 7;

    localparam logic [1:0] SLOT_R_ONES = 2'd0;
    localparam logic [1:0] SLOT_R_TENS = 2'd1;
    localparam logic [1:0] SLOT_L_ONES = 2'd2;
    localparam logic [1:0] SLOT_L_TENS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } scan_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, 7-bit binary (0..99) to two BCD digits
module bin2bcd_seq
    import pong_display_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BCD_ITER-1:0] bin,
    output logic                done,
    output logic [DIGIT_W-1:0]  tens,
    output logic [DIGIT_W-1:0]  ones
);

    localparam int SH_W = 2 * DIGIT_W + BCD_ITER;

    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] adjusted;
    logic [2:0]      iter_left;

    // Add-3 correction on both BCD nibbles before each shift; input is pre-clamped so no hundreds digit.
    always_comb begin
        adjusted = shreg;
        if (shreg[SH_W-1 -: DIGIT_W] >= 4'd5) begin
            adjusted[SH_W-1 -: DIGIT_W] = shreg[SH_W-1 -: DIGIT_W] + 4'd3;
        end
        if (shreg[SH_W-DIGIT_W-1 -: DIGIT_W] >= 4'd5) begin
            adjusted[SH_W-DIGIT_W-1 -: DIGIT_W] = shreg[SH_W-DIGIT_W-1 -: DIGIT_W] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            iter_left <= '0;
        end else if (start) begin
            shreg     <= {{(2 * DIGIT_W){1'b0}}, bin};
            iter_left <= 3'(BCD_ITER);
        end else if (iter_left != 3'd0) begin
            shreg     <= {adjusted[SH_W-2:0], 1'b0};
            iter_left <= iter_left - 3'd1;
        end
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign done = (iter_left == 3'd1);
    assign tens = shreg[SH_W-1 -: DIGIT_W];
    assign ones = shreg[SH_W-DIGIT_W-1 -: DIGIT_W];

endmodule

// File: rtl/score_display_scanner.sv
// rtl/score_display_scanner.sv - BCD-converts two scores and scans four digits to the decoder; optional DISPLAY_TEST_EN
module score_display_scanner
    import pong_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SCORE_W     = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score_left,
    input  logic [SCORE_W-1:0] score_right,
    output logic [1:0]         en,
    output logic [DIGIT_W-1:0] num,
    output logic               busy
`ifdef DISPLAY_TEST_EN
    ,
    input  logic               test_mode
`endif
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0]    refresh_cnt;
    logic                refresh_tc;
    logic [BCD_ITER-1:0] sat_left;
    logic [BCD_ITER-1:0] sat_right;
    logic [BCD_ITER-1:0] cap_left;
    logic [BCD_ITER-1:0] cap_right;
    scan_state_t         state;
    scan_state_t         state_next;
    logic                conv_start;
    logic                commit;
    logic                done_left;
    logic                done_right;
    logic [DIGIT_W-1:0]  tens_left;
    logic [DIGIT_W-1:0]  ones_left;
    logic [DIGIT_W-1:0]  tens_right;
    logic [DIGIT_W-1:0]  ones_right;
    logic [DIGIT_W-1:0]  digit [NUM_SLOTS];

    assign refresh_tc = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            en          <= 2'd0;
        end else if (refresh_tc) begin
            refresh_cnt <= '0;
            en          <= en + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sat_left  = (score_left  > SCORE_W'(MAX_SCORE)) ? BCD_ITER'(MAX_SCORE) : score_left[BCD_ITER-1:0];
        sat_right = (score_right > SCORE_W'(MAX_SCORE)) ? BCD_ITER'(MAX_SCORE) : score_right[BCD_ITER-1:0];
    end

    // Comparing against the saturated copy keeps an over-range score from retriggering forever.
    always_comb begin
        state_next = state;
        conv_start = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((sat_left != cap_left) || (sat_right != cap_right)) begin
                    conv_start = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (done_left && done_right) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cap_left  <= '0;
            cap_right <= '0;
        end else begin
            state <= state_next;
            if (conv_start) begin
                cap_left  <= sat_left;
                cap_right <= sat_right;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                digit[i] <= '0;
            end
        end else if (commit) begin
            digit[SLOT_R_ONES] <= ones_right;
            digit[SLOT_R_TENS] <= tens_right;
            digit[SLOT_L_ONES] <= ones_left;
            digit[SLOT_L_TENS] <= tens_left;
        end
    end

    bin2bcd_seq u_conv_left (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (sat_left),
        .done  (done_left),
        .tens  (tens_left),
        .ones  (ones_left)
    );

    bin2bcd_seq u_conv_right (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (sat_right),
        .done  (done_right),
        .tens  (tens_right),
        .ones  (ones_right)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        num = digit[en];
`ifdef DISPLAY_TEST_EN
        if (test_mode) begin
            num = 4'd8;
        end
`endif
    end

endmodule

// File: tb/tb_score_display_scanner.sv
// tb/tb_score_display_scanner.sv - randomized self-checking bench for score_display_scanner against a timing-level model
module tb_score_display_scanner;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] score_left = '0;
    logic [6:0] score_right = '0;
    logic [1:0] en;
    logic [3:0] num;
    logic       busy;
`ifdef DISPLAY_TEST_EN
    logic       test_mode = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    int m_cnt, m_en, m_cap_l, m_cap_r, m_disp_l, m_disp_r, m_timer;

    score_display_scanner #(
        .REFRESH_DIV (DIV),
        .SCORE_W     (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .score_left  (score_left),
        .score_right (score_right),
        .en          (en),
        .num         (num),
        .busy        (busy)
`ifdef DISPLAY_TEST_EN
        ,
        .test_mode   (test_mode)
`endif
    );

    always #5 clk = ~clk;

    function automatic int sat(input int s);
        return (s > 99) ? 99 : s;
    endfunction

    function automatic int m_num();
`ifdef DISPLAY_TEST_EN
        if (test_mode) return 8;
`endif
        case (m_en)
            0: return m_disp_r % 10;
            1: return m_disp_r / 10;
            2: return m_disp_l % 10;
            default: return m_disp_l / 10;
        endcase
    endfunction

    // Scores appear 8 clocks after they are captured; the display counter ticks every DIV clocks.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_en = 0; m_cap_l = 0; m_cap_r = 0;
            m_disp_l = 0; m_disp_r = 0; m_timer = 0;
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_en = (m_en + 1) % 4;
            end
            if (m_timer == 0) begin
                if (sat(int'(score_left)) != m_cap_l || sat(int'(score_right)) != m_cap_r) begin
                    m_cap_l = sat(int'(score_left));
                    m_cap_r = sat(int'(score_right));
                    m_timer = 8;
                end
            end else begin
                m_timer = m_timer - 1;
                if (m_timer == 0) begin
                    m_disp_l = m_cap_l;
                    m_disp_r = m_cap_r;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        score_left = 7'd0;
        score_right = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (en !== 2'd0) begin miscompares++; $display("FAIL reset_en: got %0d want 0", en); end
        vectors++; if (num !== 4'd0) begin miscompares++; $display("FAIL reset_num: got %0d want 0", num); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++; if (en !== 2'(m_en)) begin miscompares++; $display("FAIL refresh_en: got %0d want %0d", en, m_en); end
            vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL refresh_num: got %0d want %0d", num, m_num()); end
            vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL refresh_busy: got %0b want %0b", busy, m_timer != 0); end
        end
    endtask

    task automatic test_conversion();
        int busy_cycles;
        logic [3:0] seen [4];
        busy_cycles = 0;
        score_right = 7'd47;
        score_left = 7'd5;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            vectors++; if (en !== 2'(m_en)) begin miscompares++; $display("FAIL conv_en: got %0d want %0d", en, m_en); end
            vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL conv_num: got %0d want %0d", num, m_num()); end
            vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL conv_busy: got %0b want %0b", busy, m_timer != 0); end
        end
        vectors++; if (busy_cycles != 8) begin miscompares++; $display("FAIL conv_busy_len: got %0d want 8", busy_cycles); end
        for (int s = 0; s < 4; s++) seen[s] = 'x;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            seen[en] = num;
        end
        vectors++; if (seen[0] !== 4'd7) begin miscompares++; $display("FAIL conv_slot0: got %0d want 7", seen[0]); end
        vectors++; if (seen[1] !== 4'd4) begin miscompares++; $display("FAIL conv_slot1: got %0d want 4", seen[1]); end
        vectors++; if (seen[2] !== 4'd5) begin miscompares++; $display("FAIL conv_slot2: got %0d want 5", seen[2]); end
        vectors++; if (seen[3] !== 4'd0) begin miscompares++; $display("FAIL conv_slot3: got %0d want 0", seen[3]); end
    endtask

    task automatic test_saturation();
        logic [3:0] seen [4];
        score_left = 7'd120;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL sat_num: got %0d want %0d", num, m_num()); end
            vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL sat_busy: got %0b want %0b", busy, m_timer != 0); end
        end
        for (int s = 0; s < 4; s++) seen[s] = 'x;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            seen[en] = num;
        end
        vectors++; if (seen[2] !== 4'd9) begin miscompares++; $display("FAIL sat_slot2: got %0d want 9", seen[2]); end
        vectors++; if (seen[3] !== 4'd9) begin miscompares++; $display("FAIL sat_slot3: got %0d want 9", seen[3]); end
    endtask

    task automatic test_mid_shift();
        int falls, latency;
        logic prev_busy;
        logic [3:0] seen [4];
        score_right = 7'd12;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL mid_busy: got %0b want %0b", busy, m_timer != 0); end
        end
        score_right = 7'd13;
        falls = 0;
        latency = 0;
        prev_busy = busy;
        while (falls < 2 && latency < 40) begin
            @(negedge clk);
            latency++;
            if (prev_busy === 1'b1 && busy === 1'b0) falls++;
            prev_busy = busy;
            vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL mid_num: got %0d want %0d", num, m_num()); end
            vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL mid_busy2: got %0b want %0b", busy, m_timer != 0); end
        end
        vectors++; if (falls != 2 || latency > 17) begin miscompares++; $display("FAIL mid_latency: got %0d clocks (%0d commits) want <=17 with 2 commits", latency, falls); end
        for (int s = 0; s < 4; s++) seen[s] = 'x;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            seen[en] = num;
        end
        vectors++; if (seen[0] !== 4'd3) begin miscompares++; $display("FAIL mid_slot0: got %0d want 3", seen[0]); end
        vectors++; if (seen[1] !== 4'd1) begin miscompares++; $display("FAIL mid_slot1: got %0d want 1", seen[1]); end
    endtask

    task automatic test_reset_abort();
        int busy_seen;
        score_right = 7'd63;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL abort_busy: got %0b want %0b", busy, m_timer != 0); end
        end
        reset = 1'b1;
        score_right = 7'd0;
        score_left = 7'd0;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy_rst: got %0b want 0", busy); end
        vectors++; if (num !== 4'd0) begin miscompares++; $display("FAIL abort_num_rst: got %0d want 0", num); end
        busy_seen = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
            vectors++; if (num !== 4'd0) begin miscompares++; $display("FAIL abort_num: got %0d want 0", num); end
            vectors++; if (en !== 2'(m_en)) begin miscompares++; $display("FAIL abort_en: got %0d want %0d", en, m_en); end
        end
        vectors++; if (busy_seen != 0) begin miscompares++; $display("FAIL abort_no_restart: got %0d busy clocks want 0", busy_seen); end
    endtask

    task automatic test_random();
        int hold, pick;
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 9);
            if (pick >= 2) begin
                if (pick != 3) score_left = 7'($urandom_range(0, 127));
                if (pick != 4) score_right = 7'($urandom_range(0, 127));
            end else begin
                score_left = score_left;
                score_right = score_right;
            end
            hold = $urandom_range(1, 20);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                vectors++; if (en !== 2'(m_en)) begin miscompares++; $display("FAIL rand_en: got %0d want %0d", en, m_en); end
                vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL rand_num: got %0d want %0d (L=%0d R=%0d)", num, m_num(), score_left, score_right); end
                vectors++; if (busy !== (m_timer != 0)) begin miscompares++; $display("FAIL rand_busy: got %0b want %0b", busy, m_timer != 0); end
            end
        end
    endtask

`ifdef DISPLAY_TEST_EN
    task automatic test_display_test();
        score_right = 7'd3;
        score_left = 7'd9;
        repeat (20) @(negedge clk);
        test_mode = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vectors++; if (num !== 4'd8) begin miscompares++; $display("FAIL tm_num: got %0d want 8", num); end
            vectors++; if (en !== 2'(m_en)) begin miscompares++; $display("FAIL tm_en: got %0d want %0d", en, m_en); end
        end
        test_mode = 1'b0;
        #1;
        vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL tm_release: got %0d want %0d", num, m_num()); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vectors++; if (num !== 4'(m_num())) begin miscompares++; $display("FAIL tm_after: got %0d want %0d", num, m_num()); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_conversion();
        test_saturation();
        test_mid_shift();
        test_reset_abort();
        test_random();
`ifdef DISPLAY_TEST_EN
        test_display_test();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
